pht_update_scheduler: RTL and testbench



---
 rtl/pht_update_scheduler.sv | 169 ++++++++++++++++
 tb/tb_pht_update_scheduler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pht_update_scheduler.sv
// pht_update_scheduler: write-port scheduler for the multi-bank PHT counter RAM.
// Buffers up to two counter updates per cycle in an in-order circular queue
// and issues them to two RAM write ports. Two writes never target the same
// bank in one cycle. Also runs the PHT initialisation sweep.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   initStart              restart init sweep and flush queue
//   upValid/upIndex/upValue  two update lanes (lane 1 is younger)
//   upReady                both lanes accepted this cycle
//   we/wa/wv               two RAM write ports
//   initBusy               init sweep in progress
//   queueCount             occupied queue entries
module pht_update_scheduler #(
  parameter int unsigned ENTRY_NUM   = 1024,
  parameter int unsigned INDEX_WIDTH = 10,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned BANK_NUM    = 2,
  parameter int unsigned QUEUE_DEPTH = 8,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = 8'hAA
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  initStart,
  input  logic                                  upValid [2],
  input  logic [INDEX_WIDTH-1:0]                upIndex [2],
  input  logic [DATA_WIDTH-1:0]                 upValue [2],
  output logic                                  upReady,
  output logic                                  we [2],
  output logic [INDEX_WIDTH-1:0]                wa [2],
  output logic [DATA_WIDTH-1:0]                 wv [2],
  output logic                                  initBusy,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]      queueCount
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
  // Bank bits of an index; a zero mask (single bank) makes every pair conflict.
  localparam logic [INDEX_WIDTH-1:0] BANK_MASK = INDEX_WIDTH'(BANK_NUM - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] sweep_q, sweep_d;
  logic [PTR_W-1:0]       head_q, head_d;
  logic [PTR_W-1:0]       tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [INDEX_WIDTH-1:0] q_idx_q [QUEUE_DEPTH];
  logic [INDEX_WIDTH-1:0] q_idx_d [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0]  q_val_q [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0]  q_val_d [QUEUE_DEPTH];

  logic             coalesce_c, enq0_c, enq1_c, iss0_c, iss1_c;
  logic [PTR_W-1:0] head1_c, wptr_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Accept/issue decisions
  always_comb begin
    head1_c    = ptr_inc(head_q);
    upReady    = (state_q == ST_RUN) &&
                 ((CNT_W'(QUEUE_DEPTH) - count_q) >= CNT_W'(2));
    // Same index on both lanes: the younger lane supersedes the older one.
    coalesce_c = upValid[0] && upValid[1] && (upIndex[0] == upIndex[1]);
    enq0_c     = upReady && upValid[0] && !coalesce_c;
    enq1_c     = upReady && upValid[1];
    iss0_c     = (state_q == ST_RUN) && (count_q != '0);
    iss1_c     = iss0_c && (count_q >= CNT_W'(2)) &&
                 (((q_idx_q[head_q] ^ q_idx_q[head1_c]) & BANK_MASK) != '0);
  end

  // Write-port outputs
  always_comb begin
    we[0] = 1'b0;
    wa[0] = '0;
    wv[0] = '0;
    we[1] = 1'b0;
    wa[1] = '0;
    wv[1] = '0;
    if (state_q == ST_INIT) begin
      we[0] = 1'b1;
      wa[0] = sweep_q;
      wv[0] = INIT_VALUE;
    end else begin
      if (iss0_c) begin
        we[0] = 1'b1;
        wa[0] = q_idx_q[head_q];
        wv[0] = q_val_q[head_q];
      end
      if (iss1_c) begin
        we[1] = 1'b1;
        wa[1] = q_idx_q[head1_c];
        wv[1] = q_val_q[head1_c];
      end
    end
  end

  assign initBusy   = (state_q == ST_INIT);
  assign queueCount = count_q;

  // Next-state: sweep, enqueue, dequeue, flush
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    q_idx_d = q_idx_q;
    q_val_d = q_val_q;
    wptr_c  = tail_q;

    if (state_q == ST_INIT) begin
      sweep_d = sweep_q + INDEX_WIDTH'(1);
      if (sweep_q == INDEX_WIDTH'(ENTRY_NUM - 1)) begin
        state_d = ST_RUN;
        sweep_d = '0;
      end
    end

    if (enq0_c) begin
      q_idx_d[wptr_c] = upIndex[0];
      q_val_d[wptr_c] = upValue[0];
      wptr_c          = ptr_inc(wptr_c);
    end
    if (enq1_c) begin
      q_idx_d[wptr_c] = upIndex[1];
      q_val_d[wptr_c] = upValue[1];
      wptr_c          = ptr_inc(wptr_c);
    end
    tail_d = wptr_c;

    if (iss1_c)      head_d = ptr_inc(head1_c);
    else if (iss0_c) head_d = head1_c;

    count_d = count_q + CNT_W'(enq0_c) + CNT_W'(enq1_c)
                      - CNT_W'(iss0_c) - CNT_W'(iss1_c);

    if (initStart) begin
      state_d = ST_INIT;
      sweep_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      q_idx_q <= '{default: '0};
      q_val_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      q_idx_q <= q_idx_d;
      q_val_q <= q_val_d;
    end
  end

endmodule

// File: tb/tb_pht_update_scheduler.sv
// Directed bench for pht_update_scheduler with an in-order write scoreboard.
module tb_pht_update_scheduler;

  localparam int unsigned ENTRY_NUM   = 16;
  localparam int unsigned INDEX_WIDTH = 4;
  localparam int unsigned DATA_WIDTH  = 8;
  localparam int unsigned BANK_NUM    = 2;
  localparam int unsigned QUEUE_DEPTH = 4;
  localparam int unsigned CNT_W       = $clog2(QUEUE_DEPTH + 1);

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   init_start = 1'b0;
  logic                   up_valid [2];
  logic [INDEX_WIDTH-1:0] up_index [2];
  logic [DATA_WIDTH-1:0]  up_value [2];
  logic                   up_ready;
  logic                   we [2];
  logic [INDEX_WIDTH-1:0] wa [2];
  logic [DATA_WIDTH-1:0]  wv [2];
  logic                   init_busy;
  logic [CNT_W-1:0]       queue_count;

  pht_update_scheduler #(
    .ENTRY_NUM(ENTRY_NUM), .INDEX_WIDTH(INDEX_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .BANK_NUM(BANK_NUM), .QUEUE_DEPTH(QUEUE_DEPTH), .INIT_VALUE(8'hAA)
  ) dut (
    .clk(clk), .rst(rst), .initStart(init_start),
    .upValid(up_valid), .upIndex(up_index), .upValue(up_value),
    .upReady(up_ready), .we(we), .wa(wa), .wv(wv),
    .initBusy(init_busy), .queueCount(queue_count)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; int val; } wr_t;
  wr_t exp_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int idx, input int val);
    wr_t w;
    w.idx = idx;
    w.val = val;
    exp_q.push_back(w);
  endtask

  task automatic drive(input bit v0, input int i0, input int d0,
                       input bit v1, input int i1, input int d1);
    up_valid[0] = v0;
    up_index[0] = INDEX_WIDTH'(i0);
    up_value[0] = DATA_WIDTH'(d0);
    up_valid[1] = v1;
    up_index[1] = INDEX_WIDTH'(i1);
    up_value[1] = DATA_WIDTH'(d1);
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, 1'b0, 0, 0);
  endtask

  // Monitor: every RUN write must match the oldest outstanding expected write.
  task automatic check_port(input int p);
    wr_t w;
    if (exp_q.size() == 0) begin
      chk($sformatf("unexpected_write_p%0d_wa", p), int'(wa[p]), -1);
    end else begin
      w = exp_q.pop_front();
      chk($sformatf("sb_wa_p%0d", p), int'(wa[p]), w.idx);
      chk($sformatf("sb_wv_p%0d", p), int'(wv[p]), w.val);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && !init_busy) begin
      if (we[0]) check_port(0);
      if (we[1]) begin
        chk("port1_without_port0", int'(we[0]), 1);
        chk("port_bank_distinct", int'((wa[0] ^ wa[1]) & 4'(BANK_NUM - 1)), 1);
        check_port(1);
      end
    end
  end

  initial begin
    int cnt_m;
    int k;
    int waited;
    bit rdy_m;
    idle();

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_we0", int'(we[0]), 1);
    chk("rst_wa0", int'(wa[0]), 0);
    chk("rst_wv0", int'(wv[0]), 'hAA);
    chk("rst_we1", int'(we[1]), 0);
    chk("rst_wa1", int'(wa[1]), 0);
    chk("rst_wv1", int'(wv[1]), 0);
    chk("rst_init_busy", int'(init_busy), 1);
    chk("rst_up_ready", int'(up_ready), 0);
    chk("rst_count", int'(queue_count), 0);
    rst = 1'b0;

    // Init sweep
    for (int i = 0; i < ENTRY_NUM; i++) begin
      chk("sweep_we0", int'(we[0]), 1);
      chk("sweep_wa0", int'(wa[0]), i);
      chk("sweep_wv0", int'(wv[0]), 'hAA);
      chk("sweep_we1", int'(we[1]), 0);
      chk("sweep_up_ready", int'(up_ready), 0);
      @(negedge clk);
    end
    chk("run_init_busy", int'(init_busy), 0);
    chk("run_up_ready", int'(up_ready), 1);
    chk("run_count", int'(queue_count), 0);

    // Dual issue, different banks
    drive(1'b1, 4, 3, 1'b1, 7, 1);
    push(4, 3);
    push(7, 1);
    @(negedge clk);
    idle();
    chk("dual_we0", int'(we[0]), 1);
    chk("dual_we1", int'(we[1]), 1);
    chk("dual_wa0", int'(wa[0]), 4);
    chk("dual_wa1", int'(wa[1]), 7);
    chk("dual_wv0", int'(wv[0]), 3);
    chk("dual_wv1", int'(wv[1]), 1);
    chk("dual_count", int'(queue_count), 2);
    @(negedge clk);
    chk("dual_count_drained", int'(queue_count), 0);
    chk("dual_idle_we0", int'(we[0]), 0);

    // Bank conflict: both bank 0
    drive(1'b1, 2, 11, 1'b1, 6, 12);
    push(2, 11);
    push(6, 12);
    @(negedge clk);
    idle();
    chk("conf_c1_we0", int'(we[0]), 1);
    chk("conf_c1_wa0", int'(wa[0]), 2);
    chk("conf_c1_we1", int'(we[1]), 0);
    @(negedge clk);
    chk("conf_c2_wa0", int'(wa[0]), 6);
    chk("conf_c2_we1", int'(we[1]), 0);
    @(negedge clk);
    chk("conf_count_drained", int'(queue_count), 0);

    // Coalesce: younger lane wins
    drive(1'b1, 5, 1, 1'b1, 5, 2);
    push(5, 2);
    @(negedge clk);
    idle();
    chk("coal_count", int'(queue_count), 1);
    chk("coal_wa0", int'(wa[0]), 5);
    chk("coal_wv0", int'(wv[0]), 2);
    chk("coal_we1", int'(we[1]), 0);
    @(negedge clk);
    chk("coal_count_drained", int'(queue_count), 0);
    chk("coal_idle_we0", int'(we[0]), 0);

    // Backpressure: all bank 0, one retire per cycle
    cnt_m = 0;
    k = 0;
    for (int c = 0; c < 12; c++) begin
      rdy_m = ((QUEUE_DEPTH - cnt_m) >= 2);
      chk("bp_count", int'(queue_count), cnt_m);
      chk("bp_up_ready", int'(up_ready), int'(rdy_m));
      drive(1'b1, (4 * k) % 16, k, 1'b1, (4 * k + 2) % 16, k + 100);
      if (rdy_m) begin
        push((4 * k) % 16, k);
        push((4 * k + 2) % 16, k + 100);
        k++;
      end
      cnt_m = cnt_m + (rdy_m ? 2 : 0) - ((cnt_m >= 1) ? 1 : 0);
      @(negedge clk);
    end
    idle();
    waited = 0;
    while (queue_count != 0 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    chk("bp_drain_count", int'(queue_count), 0);
    chk("bp_scoreboard_empty", exp_q.size(), 0);

    // Flush with three queued entries
    drive(1'b1, 8, 1, 1'b1, 10, 2);
    push(8, 1);
    push(10, 2);
    @(negedge clk);
    drive(1'b1, 12, 3, 1'b1, 14, 4);
    push(12, 3);
    push(14, 4);
    @(negedge clk);
    idle();
    chk("flush_pre_count", int'(queue_count), 3);
    init_start = 1'b1;
    @(posedge clk);
    #1;
    init_start = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("flush_count", int'(queue_count), 0);
    chk("flush_init_busy", int'(init_busy), 1);
    chk("flush_wa0", int'(wa[0]), 0);
    chk("flush_up_ready", int'(up_ready), 0);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      chk("flush_sweep_wa0", int'(wa[0]), i);
    end

    // Async reset at sweep index 9
    rst = 1'b1;
    #1;
    chk("midrst_wa0", int'(wa[0]), 0);
    chk("midrst_we0", int'(we[0]), 1);
    chk("midrst_init_busy", int'(init_busy), 1);
    chk("midrst_count", int'(queue_count), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (ENTRY_NUM) @(negedge clk);
    chk("final_init_busy", int'(init_busy), 0);
    chk("final_up_ready", int'(up_ready), 1);

    // One more transaction after the re-sweep
    drive(1'b1, 1, 9, 1'b1, 0, 8);
    push(1, 9);
    push(0, 8);
    @(negedge clk);
    idle();
    chk("final_we1", int'(we[1]), 1);
    @(negedge clk);
    chk("final_scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
